// File: rtl/md_timestep_sequencer.sv
// md_timestep_sequencer: run FSM for initial particle load, force/motion phase scheduling and buffer swaps.
// Optional per-phase watchdog abort is built when MD_SEQ_WATCHDOG_EN is defined.
module md_timestep_sequencer #(
    parameter int N_CELL          = 27,
    parameter int N_PARTICLES     = 300,
    parameter int SETTLE_CYCLES   = 4,
    parameter int STEP_W          = 16,
    parameter int WATCHDOG_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [STEP_W-1:0] n_steps,
    input  logic              data_in_ready,
    input  logic              p1_done,
    input  logic [N_CELL-1:0] p3_done,
    output logic              mem_set,
    output logic              phase1_ready,
    output logic              phase3_ready,
    output logic              double_buffer,
    output logic [STEP_W-1:0] step_count,
    output logic              busy,
    output logic              done,
    output logic              timeout
);
    localparam int LD_W = $clog2(N_PARTICLES + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    if (WATCHDOG_CYCLES < 2 || SETTLE_CYCLES < 1) begin : g_bad_cfg
        $error("md_timestep_sequencer: WATCHDOG_CYCLES must be >= 2 and SETTLE_CYCLES >= 1");
    end

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, P1, GAP, P3, SWAP, DONE} state_t;
    state_t state_q, state_d;
    logic [LD_W-1:0]   ld_q, ld_d;
    logic [ST_W-1:0]   st_q, st_d;
    logic [STEP_W-1:0] n_q, n_d, step_q, step_d, step_nx;
    logic mem_q, mem_d, db_q, db_d, to_q, to_d;
    logic p1r_q, p3r_q, busy_q, done_q;
    logic p1d_q, p3d_q, armed_q, armed_d, stay_ph, wd_hit;

`ifdef MD_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    assign wd_hit = (wd_q == WD_W'(WATCHDOG_CYCLES - 1));
    assign wd_d   = stay_ph ? wd_q + WD_W'(1) : '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) wd_q <= '0;
        else wd_q <= wd_d;
`else
    assign wd_hit = 1'b0;
`endif

    assign step_nx = &step_q ? step_q : step_q + STEP_W'(1);
    // A phase only counts as settled once its ready has been up for a full cycle.
    assign stay_ph = (state_d == state_q) && (state_q == P1 || state_q == P3);
    assign armed_d = stay_ph;

    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        st_d    = st_q;
        n_d     = n_q;
        step_d  = step_q;
        db_d    = db_q;
        mem_d   = mem_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (start) begin
                n_d     = n_steps;
                ld_d    = '0;
                to_d    = 1'b0;
                state_d = LOAD;
            end
            LOAD: if (data_in_ready) begin
                ld_d = ld_q + LD_W'(1);
                if (ld_q == LD_W'(N_PARTICLES - 1)) begin
                    state_d = SETTLE;
                    mem_d   = 1'b1;
                    st_d    = '0;
                end
            end
            SETTLE: begin
                st_d = st_q + ST_W'(1);
                if (st_q == ST_W'(SETTLE_CYCLES - 1)) state_d = (n_q == '0) ? DONE : P1;
            end
            P1: if (armed_q && p1d_q) state_d = GAP;
                else if (wd_hit) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end
            GAP: state_d = P3;
            P3: if (armed_q && p3d_q) state_d = SWAP;
                else if (wd_hit) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end
            SWAP: begin
                db_d    = ~db_q;
                step_d  = step_nx;
                state_d = (step_nx == n_q) ? DONE : P1;
            end
            DONE: if (start) begin
                n_d     = n_steps;
                step_d  = '0;
                to_d    = 1'b0;
                state_d = (n_steps == '0) ? DONE : P1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            ld_q    <= '0;
            st_q    <= '0;
            n_q     <= '0;
            step_q  <= '0;
            db_q    <= 1'b0;
            mem_q   <= 1'b0;
            to_q    <= 1'b0;
            p1r_q   <= 1'b0;
            p3r_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p1d_q   <= 1'b0;
            p3d_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            n_q     <= n_d;
            step_q  <= step_d;
            db_q    <= db_d;
            mem_q   <= mem_d;
            to_q    <= to_d;
            p1r_q   <= state_d == P1;
            p3r_q   <= state_d == P3;
            busy_q  <= state_d != IDLE && state_d != DONE;
            done_q  <= state_d == DONE;
            p1d_q   <= p1_done;
            p3d_q   <= &p3_done;
            armed_q <= armed_d;
        end

    assign mem_set       = mem_q;
    assign phase1_ready  = p1r_q;
    assign phase3_ready  = p3r_q;
    assign double_buffer = db_q;
    assign step_count    = step_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout       = to_q;
endmodule

// File: tb/tb_md_timestep_sequencer.sv
// tb_md_timestep_sequencer: directed bench for the MD run sequencer (load, steps, stale done, rerun, reset, watchdog).
module tb_md_timestep_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, data_in_ready, p1_done;
    logic [15:0] n_steps;
    logic [26:0] p3_done;
    logic        mem_set, phase1_ready, phase3_ready, double_buffer, busy, done, timeout;
    logic [15:0] step_count;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        seen;

    md_timestep_sequencer #(
        .N_CELL(27), .N_PARTICLES(300), .SETTLE_CYCLES(4), .STEP_W(16), .WATCHDOG_CYCLES(50)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .n_steps(n_steps),
        .data_in_ready(data_in_ready), .p1_done(p1_done), .p3_done(p3_done),
        .mem_set(mem_set), .phase1_ready(phase1_ready), .phase3_ready(phase3_ready),
        .double_buffer(double_buffer), .step_count(step_count), .busy(busy),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem"}, {31'b0, mem_set}, 0);
        chk({tag, "_rdy"}, {30'b0, phase1_ready, phase3_ready}, 0);
        chk({tag, "_db"}, {31'b0, double_buffer}, 0);
        chk({tag, "_step"}, {16'b0, step_count}, 0);
        chk({tag, "_busy_done_to"}, {29'b0, busy, done, timeout}, 0);
    endtask

    // From P1 cycle 0: pulse p1_done so it is seen d cycles after ready rose, then land in GAP.
    task automatic p1_after(input int d);
        tick(d - 1);
        p1_done = 1'b1;
        tick(1);
        p1_done = 1'b0;
        tick(1);
    endtask

    task automatic p3_after(input int d);
        tick(d - 1);
        p3_done = '1;
        tick(1);
        p3_done = '0;
        tick(1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; n_steps = '0; data_in_ready = 1'b0; p1_done = 1'b0; p3_done = '0;
        seen = 1'b0;
        tick(2);
        chk_zero("reset");
        reset = 1'b0;
        data_in_ready = 1'b1;
        tick(2);
        chk("idle_ignores_data", {31'b0, busy}, 0);
        data_in_ready = 1'b0;
        // Initial load with irregular gaps
        start = 1'b1; n_steps = 16'd2;
        tick(1);
        start = 1'b0;
        chk("load_busy", {31'b0, busy}, 1);
        for (int i = 0; i < 300; i++) begin
            data_in_ready = 1'b1;
            tick(1);
            seen |= phase1_ready | phase3_ready;
            data_in_ready = 1'b0;
            if (i == 298) chk("mem_before_last", {31'b0, mem_set}, 0);
            if (i < 299 && i % 5 == 2) begin
                tick(1 + i % 3);
                seen |= phase1_ready | phase3_ready;
            end
        end
        chk("no_ready_in_load", {31'b0, seen}, 0);
        chk("mem_set_rise", {31'b0, mem_set}, 1);
        chk("settle_p1r0", {31'b0, phase1_ready}, 0);
        tick(3);
        chk("settle_end_p1r0", {31'b0, phase1_ready}, 0);
        tick(1);
        chk("p1_enter", {30'b0, phase1_ready, phase3_ready}, 2);
        // Step 1: dones 10 cycles after ready
        p1_after(10);
        chk("gap1_readies", {30'b0, phase1_ready, phase3_ready}, 0);
        tick(1);
        chk("p3_enter", {30'b0, phase1_ready, phase3_ready}, 1);
        p3_after(10);
        chk("swap1", {14'b0, phase3_ready, double_buffer, step_count}, 0);
        p1_done = 1'b1;
        tick(1);
        chk("step1", {14'b0, phase1_ready, double_buffer, step_count}, 32'h3_0001);
        // Step 2: stale p1_done held, partial p3 vector
        tick(1);
        chk("stale_p1_c1", {31'b0, phase1_ready}, 1);
        tick(1);
        chk("stale_gap", {30'b0, phase1_ready, phase3_ready}, 0);
        p1_done = 1'b0;
        tick(1);
        p3_done = 27'h3FF_FFFF;
        tick(5);
        chk("partial_p3_hold", {31'b0, phase3_ready}, 1);
        p3_done = 27'h7FF_FFFF;
        tick(1);
        chk("p3_bit26_latency", {31'b0, phase3_ready}, 1);
        tick(1);
        p3_done = '0;
        chk("swap2", {31'b0, phase3_ready}, 0);
        tick(1);
        chk("run_done", {13'b0, done, busy, double_buffer, step_count}, 32'h4_0002);
        // Rerun from DONE without reload
        start = 1'b1; n_steps = 16'd1;
        tick(1);
        start = 1'b0;
        chk("rerun_p1", {12'b0, mem_set, phase1_ready, done, busy, step_count}, 32'hD_0000);
        p1_after(3);
        tick(1);
        p3_after(3);
        tick(1);
        chk("rerun_done", {14'b0, done, double_buffer, step_count}, 32'h3_0001);
        start = 1'b1; n_steps = 16'd0;
        tick(1);
        start = 1'b0;
        chk("zero_steps", {13'b0, done, busy, double_buffer, step_count}, 32'h5_0000);
        // Async reset in P3
        start = 1'b1; n_steps = 16'd3;
        tick(1);
        start = 1'b0;
        p1_after(3);
        tick(1);
        chk("pre_reset_p3", {31'b0, phase3_ready}, 1);
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        tick(1);
        reset = 1'b0;
        start = 1'b1; n_steps = 16'd1;
        tick(1);
        start = 1'b0;
        chk("reload_busy", {30'b0, busy, mem_set}, 2);
        data_in_ready = 1'b1;
        tick(299);
        chk("reload_299", {31'b0, mem_set}, 0);
        tick(1);
        data_in_ready = 1'b0;
        chk("reload_300", {31'b0, mem_set}, 1);
        tick(4);
        chk("reload_p1", {31'b0, phase1_ready}, 1);
`ifdef MD_SEQ_WATCHDOG_EN
        tick(49);
        chk("wd_p1_49", {30'b0, phase1_ready, timeout}, 2);
        tick(1);
        chk("wd_abort", {28'b0, phase1_ready, phase3_ready, done, timeout}, 3);
        start = 1'b1; n_steps = 16'd0;
        tick(1);
        start = 1'b0;
        chk("wd_clear", {30'b0, done, timeout}, 2);
`else
        p1_after(3);
        tick(1);
        p3_after(3);
        tick(1);
        chk("reload_done", {14'b0, done, timeout, step_count}, 32'h2_0001);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
